// File: rtl/concurrent_assertion_pkg.sv
// Shared widths and types for the free-running wrap counter and its checker.
package concurrent_assertion_pkg;

  localparam int COUNT_W = 4;
  localparam logic [COUNT_W-1:0] COUNT_MAX = 4'd15;

  typedef logic [COUNT_W-1:0] count_t;

endpackage

// File: rtl/concurrent_assertion_if.sv
// Observation bundle for the counter outputs; the master side drives, checkers and benches listen.
interface concurrent_assertion_if;
  import concurrent_assertion_pkg::*;

  count_t count;
  logic   t;

  modport master (output count, output t);
  modport slave  (input count, input t);

endinterface

// File: rtl/concurrent_assertion_sva.sv
// Concurrent-property checker for the wrap counter; holds only checker bookkeeping, no design state.
module concurrent_assertion_sva
  import concurrent_assertion_pkg::*;
(
  input logic   clk,
  input logic   rst_n,
  input count_t count,
  input logic   t
);

  // $past is meaningless across a reset, even one that opens and closes between edges
  logic rst_seen;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rst_seen <= 1'b1;
    else        rst_seen <= 1'b0;
  end

  a_inc: assert property (@(posedge clk) disable iff (!rst_n)
    !rst_seen |-> (count == count_t'($past(count) + 1'b1)))
    else $error("concurrent_assertion: increment violated, count=%0d t=%0b", count, t);

  a_tog: assert property (@(posedge clk) disable iff (!rst_n)
    !rst_seen |-> ((t != $past(t)) == ($past(count) == COUNT_MAX)))
    else $error("concurrent_assertion: toggle violated, count=%0d t=%0b", count, t);

  a_known: assert property (@(posedge clk) disable iff (!rst_n)
    !$isunknown({count, t}))
    else $error("concurrent_assertion: unknown output, count=%0d t=%0b", count, t);

  c_wrap: cover property (@(posedge clk) disable iff (!rst_n)
    !rst_seen && ($past(count) == COUNT_MAX) && (count == '0));

  c_rise: cover property (@(posedge clk) disable iff (!rst_n) $rose(t));

endmodule

// File: rtl/concurrent_assertion.sv
// Free-running 4-bit wrap counter with a flag that flips on every wrap.
// Define CONCURRENT_ASSERTION_SVA_EN to compile in the internal property checker.
module concurrent_assertion
  import concurrent_assertion_pkg::*;
(
  input  logic   clk,
  input  logic   rst_n,
  output count_t count,
  output logic   t
);

  // Carry out of the increment doubles as the wrap indicator
  logic [COUNT_W:0] sum_p0;
  logic             wrap_p0;

  assign sum_p0  = {1'b0, count} + 1'b1;
  assign wrap_p0 = sum_p0[COUNT_W];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
      t     <= 1'b0;
    end else begin
      count <= sum_p0[COUNT_W-1:0];
      if (wrap_p0) t <= ~t;
    end
  end

`ifdef CONCURRENT_ASSERTION_SVA_EN
  concurrent_assertion_sva u_sva (
    .clk   (clk),
    .rst_n (rst_n),
    .count (count),
    .t     (t)
  );
`else
`endif

endmodule

// File: tb/tb_concurrent_assertion.sv
// Directed plus randomized bench for the wrap counter against an edge-count reference model.
module tb_concurrent_assertion;
  import concurrent_assertion_pkg::*;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;

  concurrent_assertion_if bus ();

  concurrent_assertion dut (
    .clk   (clk),
    .rst_n (rst_n),
    .count (bus.count),
    .t     (bus.t)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  // Reference model: rising edges seen with rst_n high since the last reset
  int n = 0;

  task automatic chk(input string tag);
    count_t exp_c;
    logic   exp_t;
    exp_c = count_t'(n % 16);
    exp_t = ((n / 16) % 2) == 1;
    checks++;
    assert (bus.count === exp_c && bus.t === exp_t) else begin
      errors++;
      $error("FAIL %s: observed count=%0d t=%0b, expected count=%0d t=%0b",
             tag, bus.count, bus.t, exp_c, exp_t);
    end
  endtask

  task automatic step(input string tag);
    @(posedge clk);
    #1;
    n++;
    chk(tag);
  endtask

  initial begin
    int a, b, len;

    // Power-on reset: low from just after time 0 until 20 ns
    #1 rst_n = 1'b0;
    #1 chk("reset_early");
    #10 chk("reset_late");
    #8 rst_n = 1'b1;
    n = 0;
    #1 chk("release_hold");

    step("first_edge");
    for (int i = 0; i < 47; i++) step("run48");

    // Mid-count reset between edges with count=9 and t=1
    while (!((n % 16) == 9 && ((n / 16) % 2) == 1)) step("to_nine");
    #3 rst_n = 1'b0;
    #1;
    n = 0;
    chk("mid_reset_async");
    #2 rst_n = 1'b1;
    #1 chk("mid_reset_released");
    step("after_mid_reset");

    // Reset coincident with the 15 -> 0 edge: no increment, no toggle
    while ((n % 16) != 15) step("to_fifteen");
    @(posedge clk);
    rst_n = 1'b0;
    #1;
    n = 0;
    chk("edge_reset");
    for (int i = 0; i < 2; i++) begin
      @(posedge clk);
      #1 chk("held_reset");
    end
    #3 rst_n = 1'b1;
    step("after_edge_reset");

    // Randomized run lengths with short reset glitches between edges
    for (int k = 0; k < 8; k++) begin
      len = $urandom_range(1, 40);
      for (int i = 0; i < len; i++) step("rand_run");
      a = $urandom_range(1, 3);
      b = $urandom_range(1, 3);
      #(a) rst_n = 1'b0;
      #1;
      n = 0;
      chk("rand_glitch");
      #(b) rst_n = 1'b1;
      step("rand_restart");
    end

    for (int i = 0; i < 40; i++) step("final_run");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Hard bound so the run always terminates
  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish, expected completion before 100000 ns");
    $fatal(1, "timeout");
  end

endmodule
